// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the Forth CPU interrupt controller: PC next-address
// select codes, vector addresses and sequencer state encodings.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    PC_NEXTX_NEXT  = 3'b000,
    PC_NEXTX_INTV0 = 3'b001,
    PC_NEXTX_INTV1 = 3'b010,
    PC_NEXTX_INTR0 = 3'b011,
    PC_NEXTX_INTR1 = 3'b100
  } pc_nextx_t;

  localparam logic [15:0] INTV0 = 16'h0004;
  localparam logic [15:0] INTV1 = 16'h0008;

  // Encodings double as the IN_SERVICE bits {INT1, INT0}
  typedef enum logic [1:0] {
    INTC_IDLE  = 2'b00,
    INTC_SVC0  = 2'b01,
    INTC_SVC1  = 2'b10,
    INTC_SVC01 = 2'b11
  } intc_state_t;

endpackage

// File: rtl/interrupt_controller_irq_edge_detect.sv
// Per-source request path: optional two-flop synchroniser (INTC_SYNC_EN),
// rising-edge detector and pending latch with acknowledge clear.
module irq_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IRQ,
  input  logic ACK,
  output logic PENDING
);

  logic irq_s;
  logic hist;
  logic rise;

`ifdef INTC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync <= '0;
    else       sync <= {sync[0], IRQ};
  end

  assign irq_s = sync[1];
`else
  assign irq_s = IRQ;
`endif

  assign rise = irq_s & ~hist;

  // A new edge on the acknowledge cycle wins over the clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hist    <= 1'b0;
      PENDING <= 1'b0;
    end else begin
      hist    <= irq_s;
      PENDING <= rise | (PENDING & ~ACK);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt sequencer driving the PC next-address select and return-save
// strobes. Optional IRQ synchronisers enabled by defining INTC_SYNC_EN.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FETCH,
  input  logic       PC_ENX,
  input  logic       IRQ0,
  input  logic       IRQ1,
  input  logic       RETI,
  input  logic       IE_SET,
  input  logic       IE_CLR,
  output logic [2:0] PC_NEXTX,
  output logic       PC_LD_INT0X,
  output logic       PC_LD_INT1X,
  output logic [1:0] INT_ACK,
  output logic [1:0] PENDING,
  output logic [1:0] IN_SERVICE,
  output logic       GIE
);

  intc_state_t state, state_nxt;
  logic        commit;
  logic        take0;
  logic        take1;

  irq_edge_detect u_edge0 (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ     (IRQ0),
    .ACK     (INT_ACK[0]),
    .PENDING (PENDING[0])
  );

  irq_edge_detect u_edge1 (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ     (IRQ1),
    .ACK     (INT_ACK[1]),
    .PENDING (PENDING[1])
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       GIE <= 1'b0;
    else if (IE_CLR) GIE <= 1'b0;
    else if (IE_SET) GIE <= 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= INTC_IDLE;
    else       state <= state_nxt;
  end

  assign commit     = FETCH & PC_ENX;
  assign take0      = GIE & PENDING[0] & ((state == INTC_IDLE) | (state == INTC_SVC1));
  assign take1      = GIE & PENDING[1] & ~PENDING[0] & (state == INTC_IDLE);
  assign IN_SERVICE = state;

  // RETI always owns the fetch, so a spurious RETI in IDLE also defers takes
  always_comb begin
    state_nxt   = state;
    PC_NEXTX    = PC_NEXTX_NEXT;
    PC_LD_INT0X = 1'b0;
    PC_LD_INT1X = 1'b0;
    INT_ACK     = '0;
    if (commit) begin
      if (RETI) begin
        unique case (state)
          INTC_SVC0: begin
            PC_NEXTX  = PC_NEXTX_INTR0;
            state_nxt = INTC_IDLE;
          end
          INTC_SVC01: begin
            PC_NEXTX  = PC_NEXTX_INTR0;
            state_nxt = INTC_SVC1;
          end
          INTC_SVC1: begin
            PC_NEXTX  = PC_NEXTX_INTR1;
            state_nxt = INTC_IDLE;
          end
          default: ;
        endcase
      end else if (take0) begin
        PC_NEXTX    = PC_NEXTX_INTV0;
        PC_LD_INT0X = 1'b1;
        INT_ACK[0]  = 1'b1;
        state_nxt   = (state == INTC_SVC1) ? INTC_SVC01 : INTC_SVC0;
      end else if (take1) begin
        PC_NEXTX    = PC_NEXTX_INTV1;
        PC_LD_INT1X = 1'b1;
        INT_ACK[1]  = 1'b1;
        state_nxt   = INTC_SVC1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; edge-to-pending
// latency follows INTC_SYNC_EN.
module tb_interrupt_controller;

`ifdef INTC_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FETCH = 1'b0;
  logic       PC_ENX = 1'b0;
  logic       IRQ0 = 1'b0;
  logic       IRQ1 = 1'b0;
  logic       RETI = 1'b0;
  logic       IE_SET = 1'b0;
  logic       IE_CLR = 1'b0;
  logic [2:0] PC_NEXTX;
  logic       PC_LD_INT0X;
  logic       PC_LD_INT1X;
  logic [1:0] INT_ACK;
  logic [1:0] PENDING;
  logic [1:0] IN_SERVICE;
  logic       GIE;

  int errors = 0;
  int checks = 0;

  interrupt_controller dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FETCH       (FETCH),
    .PC_ENX      (PC_ENX),
    .IRQ0        (IRQ0),
    .IRQ1        (IRQ1),
    .RETI        (RETI),
    .IE_SET      (IE_SET),
    .IE_CLR      (IE_CLR),
    .PC_NEXTX    (PC_NEXTX),
    .PC_LD_INT0X (PC_LD_INT0X),
    .PC_LD_INT1X (PC_LD_INT1X),
    .INT_ACK     (INT_ACK),
    .PENDING     (PENDING),
    .IN_SERVICE  (IN_SERVICE),
    .GIE         (GIE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Strobe group {PC_NEXTX, LD1, LD0, ACK} while a fetch is presented
  task automatic chk_fetch(input string tag, input logic [2:0] nx, input logic ld1,
                           input logic ld0, input logic [1:0] ack);
    #1;
    chk(tag, {1'b0, PC_NEXTX, PC_LD_INT1X, PC_LD_INT0X, INT_ACK},
             {1'b0, nx, ld1, ld0, ack});
  endtask

  task automatic fetch_on(input logic reti);
    FETCH = 1'b1; PC_ENX = 1'b1; RETI = reti;
  endtask

  task automatic fetch_off();
    FETCH = 1'b0; PC_ENX = 1'b0; RETI = 1'b0;
  endtask

  // Raise the requests, wait for them to register, then drop and let history clear
  task automatic pulse(input logic r0, input logic r1);
    IRQ0 = r0; IRQ1 = r1;
    repeat (LAT) tick();
    IRQ0 = 1'b0; IRQ1 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_nextx", {5'd0, PC_NEXTX}, 8'h00);
    chk("rst_strobes", {4'd0, PC_LD_INT1X, PC_LD_INT0X, INT_ACK}, 8'h00);
    chk("rst_pend_svc_gie", {3'd0, PENDING, IN_SERVICE, GIE}, 8'h00);
    RESET = 1'b0;
    tick();

    // GIE: set, both-high clears
    IE_SET = 1'b1; tick(); IE_SET = 1'b0;
    chk("gie_set", {7'd0, GIE}, 8'h01);
    IE_SET = 1'b1; IE_CLR = 1'b1; tick(); IE_SET = 1'b0; IE_CLR = 1'b0;
    chk("gie_clr_wins", {7'd0, GIE}, 8'h00);
    IE_SET = 1'b1; tick(); IE_SET = 1'b0;

    // 1: IRQ0 latency and take
    IRQ0 = 1'b1;
    repeat (LAT - 1) tick();
    chk("lat_before", {6'd0, PENDING}, 8'h00);
    tick();
    chk("lat_at", {6'd0, PENDING}, 8'h01);
    IRQ0 = 1'b0;
    repeat (3) tick();
    fetch_on(1'b0);
    chk_fetch("t1_take0", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();
    chk("t1_after", {4'd0, IN_SERVICE, PENDING}, 8'h04);
    chk("t1_idle_nextx", {5'd0, PC_NEXTX}, 8'h00);
    fetch_on(1'b1);
    chk_fetch("t1_reti", 3'b011, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    chk("t1_svc_idle", {6'd0, IN_SERVICE}, 8'h00);

    // 2: masked IRQ1 held, then taken after EI
    IE_CLR = 1'b1; tick(); IE_CLR = 1'b0;
    pulse(1'b0, 1'b1);
    chk("t2_pend", {6'd0, PENDING}, 8'h02);
    fetch_on(1'b0);
    chk_fetch("t2_masked", 3'b000, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    chk("t2_held", {4'd0, IN_SERVICE, PENDING}, 8'h02);
    IE_SET = 1'b1; tick(); IE_SET = 1'b0;
    fetch_on(1'b0);
    chk_fetch("t2_take1", 3'b010, 1'b1, 1'b0, 2'b10);
    tick(); fetch_off();
    chk("t2_after", {4'd0, IN_SERVICE, PENDING}, 8'h08);

    // 3: nesting INT0 over INT1
    pulse(1'b1, 1'b0);
    chk("t3_pend", {6'd0, PENDING}, 8'h01);
    fetch_on(1'b0);
    chk_fetch("t3_nest", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();
    chk("t3_svc01", {6'd0, IN_SERVICE}, 8'h03);
    fetch_on(1'b1);
    chk_fetch("t3_reti0", 3'b011, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    chk("t3_svc1", {6'd0, IN_SERVICE}, 8'h02);
    fetch_on(1'b1);
    chk_fetch("t3_reti1", 3'b100, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    chk("t3_idle", {6'd0, IN_SERVICE}, 8'h00);

    // 4: IRQ1 blocked while in SVC0
    pulse(1'b1, 1'b0);
    fetch_on(1'b0);
    chk_fetch("t4_take0", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      fetch_on(1'b0);
      chk_fetch("t4_blocked", 3'b000, 1'b0, 1'b0, 2'b00);
      tick(); fetch_off();
    end
    chk("t4_pend", {4'd0, IN_SERVICE, PENDING}, 8'h06);
    fetch_on(1'b1);
    chk_fetch("t4_reti", 3'b011, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    fetch_on(1'b0);
    chk_fetch("t4_take1", 3'b010, 1'b1, 1'b0, 2'b10);
    tick(); fetch_off();
    chk("t4_after", {4'd0, IN_SERVICE, PENDING}, 8'h08);

    // 5: both pending with RETI in SVC1
    pulse(1'b1, 1'b1);
    chk("t5_pend", {6'd0, PENDING}, 8'h03);
    fetch_on(1'b1);
    chk_fetch("t5_reti", 3'b100, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    fetch_on(1'b0);
    chk_fetch("t5_take0", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();
    chk("t5_after", {4'd0, IN_SERVICE, PENDING}, 8'h06);
    fetch_on(1'b1); tick(); fetch_off();
    fetch_on(1'b0);
    chk_fetch("t5_take1", 3'b010, 1'b1, 1'b0, 2'b10);
    tick(); fetch_off();
    fetch_on(1'b1); tick(); fetch_off();
    chk("t5_clean", {4'd0, IN_SERVICE, PENDING}, 8'h00);

    // 6: edge on the ack cycle survives; PC_ENX=0 holds
    pulse(1'b1, 1'b0);
    IRQ0 = 1'b1;
    repeat (LAT - 1) tick();
    fetch_on(1'b0);
    chk_fetch("t6_ack", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();
    IRQ0 = 1'b0;
    chk("t6_repend", {4'd0, IN_SERVICE, PENDING}, 8'h05);
    fetch_on(1'b1);
    chk_fetch("t6_reti", 3'b011, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    FETCH = 1'b1; PC_ENX = 1'b0;
    chk_fetch("t6_noenx", 3'b000, 1'b0, 1'b0, 2'b00);
    tick(); fetch_off();
    chk("t6_hold", {4'd0, IN_SERVICE, PENDING}, 8'h01);
    fetch_on(1'b0);
    chk_fetch("t6_take0", 3'b001, 1'b0, 1'b1, 2'b01);
    tick(); fetch_off();

    // RESET mid-service with a pending request
    repeat (3) tick();
    pulse(1'b0, 1'b1);
    chk("rst2_pre", {3'd0, PENDING, IN_SERVICE, GIE}, 8'h13);
    #2 RESET = 1'b1;
    #1;
    chk("rst2_async", {3'd0, PENDING, IN_SERVICE, GIE}, 8'h00);
    tick();
    RESET = 1'b0;
    tick();
    chk("rst2_after", {3'd0, PENDING, IN_SERVICE, GIE}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Interrupt sequencer for the Forth CPU. It feeds the program counter's next-address select and interrupt-return-save strobes.
- Collects two external interrupt requests (IRQ0 highest priority, IRQ1 lower) and latches them as pending.
- At an instruction-fetch boundary, redirects the PC to vector INTV0 (0x0004) or INTV1 (0x0008) and orders the PC to save the return address.
- On RETI, selects the saved return address back into the PC.
- Tracks in-service state so that INT0 can nest over INT1.

Parameters:
None. All codes come from the shared constants file.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
FETCH  in  1  fetch-phase strobe from the sequencer
PC_ENX  in  1  PC update enable; an event commits only when FETCH & PC_ENX
IRQ0  in  1  interrupt request 0, rising-edge triggered
IRQ1  in  1  interrupt request 1, rising-edge triggered
RETI  in  1  decoded return-from-interrupt, valid during FETCH
IE_SET  in  1  set global interrupt enable (EI instruction)
IE_CLR  in  1  clear global interrupt enable (DI instruction)
PC_NEXTX  out  3  next-address select to the PC: NEXT=000, INTV0=001, INTV1=010, INTR0=011, INTR1=100
PC_LD_INT0X  out  1  save return address into INTR0
PC_LD_INT1X  out  1  save return address into INTR1
INT_ACK  out  2  one-cycle acknowledge pulse per source, on commit
PENDING  out  2  registered pending bits {IRQ1, IRQ0}
IN_SERVICE  out  2  registered in-service bits {INT1, INT0}
GIE  out  1  global interrupt enable

Behaviour:
- Reset: GIE=0, PENDING=00, state IDLE, edge-detect history=0, PC_NEXTX=NEXT, PC_LD_INT0X=0, PC_LD_INT1X=0, INT_ACK=00.
- GIE: set by IE_SET, cleared by IE_CLR, sampled every cycle; IE_CLR wins if both are high. GIE is not altered by taking an interrupt or by RETI.
- Request path: rising edge on IRQn (registered history 0, current 1) sets PENDING[n]. An edge arriving in the same cycle as that source's acknowledge leaves PENDING[n]=1, so the edge is not lost. Latency from IRQ edge to PENDING is in the Optional Feature section.
- States: IDLE, SVC1 (servicing INT1), SVC0 (servicing INT0), SVC01 (INT0 nested over INT1). IN_SERVICE decodes as IDLE=00, SVC1=10, SVC0=01, SVC01=11.
- Eligibility:
  - take0 = GIE & PENDING[0] & state in {IDLE, SVC1}.
  - take1 = GIE & PENDING[1] & ~PENDING[0] & state==IDLE.
- Commit condition: C = FETCH & PC_ENX. Outputs are combinational from registered state, PENDING, GIE, FETCH and RETI (zero latency); state updates on the CLK edge ending C.
- Priority within C: RETI > take0 > take1. An interrupt blocked by RETI is taken on the next eligible fetch.
- RETI actions:
  - In SVC0: PC_NEXTX=INTR0, next state IDLE.
  - In SVC01: PC_NEXTX=INTR0, next state SVC1.
  - In SVC1: PC_NEXTX=INTR1, next state IDLE.
  - In IDLE: PC_NEXTX=NEXT, no state change; a spurious RETI is ignored.
- take0: PC_NEXTX=INTV0, PC_LD_INT0X=1, INT_ACK[0]=1, PENDING[0] cleared. Next state is SVC0 from IDLE, SVC01 from SVC1.
- take1: PC_NEXTX=INTV1, PC_LD_INT1X=1, INT_ACK[1]=1, PENDING[1] cleared, next state SVC1.
- FETCH without PC_ENX: PC_NEXTX stays NEXT, strobes stay 0, nothing commits, pending is retained.
- Outside FETCH: PC_NEXTX=NEXT, strobes 0.
- RESET mid-service: returns immediately to IDLE, all pending dropped, GIE=0.

Optional Feature:
INTC_SYNC_EN
- Defined: each IRQ passes through a two-flop synchroniser before the edge detector. Edge-to-PENDING latency is 3 CLK edges.
- Undefined: IRQs are treated as synchronous to CLK, with a single history flop. Edge-to-PENDING latency is 1 CLK edge.
- Synchroniser flops reset to 0.

Decomposition:
- Shared constants file holds the PC_NEXTX codes (PC_NEXTX_NEXT/INTV0/INTV1/INTR0/INTR1), INTV0/INTV1 addresses, and the state encodings (INTC_IDLE, INTC_SVC1, INTC_SVC0, INTC_SVC01).
- One sub-module, irq_edge_detect, is instantiated per source. It contains the optional synchroniser, history flop and pending set/clear, with ports CLK, RESET, IRQ, ACK, PENDING.

Test Plan:
1. RESET, IE_SET, IRQ0 rising edge, then FETCH&PC_ENX: PC_NEXTX=001, PC_LD_INT0X=1, INT_ACK=01; afterwards IN_SERVICE=01, PENDING=00.
2. GIE=0, IRQ1 edge: PENDING=10 is held and no vector on FETCH. Then IE_SET and FETCH: PC_NEXTX=010, PC_LD_INT1X=1.
3. Nesting, state SVC1: IRQ0 edge then FETCH gives INTV0 and IN_SERVICE=11. First RETI gives PC_NEXTX=011 and IN_SERVICE=10; second RETI gives PC_NEXTX=100 and IN_SERVICE=00.
4. Blocking, state SVC0: IRQ1 edge then several FETCHes give PC_NEXTX=000 and PENDING=10. RETI gives 011. Next FETCH gives 010.
5. Simultaneous: IRQ0 and IRQ1 pending with RETI at the same FETCH in SVC1 gives 100. Next FETCH gives 001, leaving PENDING=10.
6. Edge during ack, and PC_ENX=0 hold: a new IRQ0 edge landing on the ack cycle leaves PENDING[0]=1. FETCH with PC_ENX=0 gives PC_NEXTX=000 and no ACK.
   - Also run latency checks with INTC_SYNC_EN on (3 edges) and off (1 edge).
